// File: rtl/mem_lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_lsu_pkg
// Description : Shared encodings for the MEM-stage load/store unit.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_lsu_pkg;

    localparam logic C_RST_ENABLE = 1'b0;

    localparam logic [3:0] C_OP_NONE = 4'd0;
    localparam logic [3:0] C_OP_LB   = 4'd1;
    localparam logic [3:0] C_OP_LBU  = 4'd2;
    localparam logic [3:0] C_OP_LH   = 4'd3;
    localparam logic [3:0] C_OP_LHU  = 4'd4;
    localparam logic [3:0] C_OP_LW   = 4'd5;
    localparam logic [3:0] C_OP_SB   = 4'd6;
    localparam logic [3:0] C_OP_SH   = 4'd7;
    localparam logic [3:0] C_OP_SW   = 4'd8;

    localparam logic [0:0] C_ST_IDLE = 1'b0;
    localparam logic [0:0] C_ST_BUS  = 1'b1;

    typedef enum logic [1:0] {
        SZ_NONE,
        SZ_BYTE,
        SZ_HALF,
        SZ_WORD
    } mem_size_e;

    // Unused encodings fall into SZ_NONE and behave as a plain writeback.
    function automatic mem_size_e op_size(input logic [3:0] op);
        case (op)
            C_OP_LB, C_OP_LBU, C_OP_SB: op_size = SZ_BYTE;
            C_OP_LH, C_OP_LHU, C_OP_SH: op_size = SZ_HALF;
            C_OP_LW, C_OP_SW:           op_size = SZ_WORD;
            default:                    op_size = SZ_NONE;
        endcase
    endfunction

    function automatic logic op_is_store(input logic [3:0] op);
        op_is_store = (op == C_OP_SB) || (op == C_OP_SH) || (op == C_OP_SW);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_lsu_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_lsu_if
// Description : Single-outstanding data-bus between the LSU and memory.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_lsu_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic                  bus_req_o;
    logic                  bus_we_o;
    logic [ADDR_W-1:0]     bus_addr_o;
    logic [DATA_W/8-1:0]   bus_be_o;
    logic [DATA_W-1:0]     bus_wdata_o;
    logic [DATA_W-1:0]     bus_rdata_i;
    logic                  bus_ack_i;

    modport master (
        output bus_req_o, bus_we_o, bus_addr_o, bus_be_o, bus_wdata_o,
        input  bus_rdata_i, bus_ack_i
    );

    modport slave (
        input  bus_req_o, bus_we_o, bus_addr_o, bus_be_o, bus_wdata_o,
        output bus_rdata_i, bus_ack_i
    );
endinterface
`default_nettype wire

// File: rtl/mem_lane_ext.sv
`default_nettype none
// ============================================================================
// Module      : mem_lane_ext
// Description : Extracts the addressed lane of read data and sign/zero extends.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_lane_ext
    import mem_lsu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int OFF_W  = 2
) (
    input  wire logic [DATA_W-1:0] rdata,
    input  wire logic [OFF_W-1:0]  off,
    input  wire logic [3:0]        op,
    output logic      [DATA_W-1:0] data
);

    logic [DATA_W-1:0] w_lane;

    assign w_lane = rdata >> {off, 3'b000};

    always_comb begin
        data = DATA_W'($signed(w_lane[31:0]));
        case (op)
            C_OP_LB:  data = DATA_W'($signed(w_lane[7:0]));
            C_OP_LBU: data = DATA_W'(w_lane[7:0]);
            C_OP_LH:  data = DATA_W'($signed(w_lane[15:0]));
            C_OP_LHU: data = DATA_W'(w_lane[15:0]);
            default:  ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_lsu.sv
`default_nettype none
// ============================================================================
// Module      : mem_lsu
// Description : MEM-stage load/store unit, one outstanding bus access at a time.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_lsu
    import mem_lsu_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int REG_ADDR_W = 5
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    input  wire logic                  valid_i,
    output logic                       ready_o,
    input  wire logic [REG_ADDR_W-1:0] waddr_i,
    input  wire logic [DATA_W-1:0]     wdata_i,
    input  wire logic                  we_i,
    input  wire logic [3:0]            mem_op_i,
    input  wire logic [ADDR_W-1:0]     mem_addr_i,
    input  wire logic [DATA_W-1:0]     mem_sdata_i,
    mem_lsu_if.master                  bus,
    output logic      [REG_ADDR_W-1:0] waddr_o,
    output logic      [DATA_W-1:0]     wdata_o,
    output logic                       we_o,
    output logic                       misalign_o
);

    localparam int C_BE_W  = DATA_W / 8;
    localparam int C_OFF_W = $clog2(C_BE_W);

    logic [0:0]            r_state;
    logic [REG_ADDR_W-1:0] r_waddr;
    logic [3:0]            r_op;
    logic [C_OFF_W-1:0]    r_off;

    mem_size_e             w_size;
    logic                  w_misalign;
    logic [C_OFF_W-1:0]    w_off;
    logic [C_BE_W-1:0]     w_be;
    logic [DATA_W-1:0]     w_sdata_rep;
    logic [DATA_W-1:0]     w_load;

    assign w_size  = op_size(mem_op_i);
    assign w_off   = mem_addr_i[C_OFF_W-1:0];
    assign ready_o = (r_state == C_ST_IDLE);

    always_comb begin
        w_misalign  = 1'b0;
        w_be        = '0;
        w_sdata_rep = '0;
        case (w_size)
            SZ_BYTE: begin
                w_be        = C_BE_W'(1) << w_off;
                w_sdata_rep = {(DATA_W/8){mem_sdata_i[7:0]}};
            end
            SZ_HALF: begin
                w_misalign  = mem_addr_i[0];
                w_be        = C_BE_W'(3) << w_off;
                w_sdata_rep = {(DATA_W/16){mem_sdata_i[15:0]}};
            end
            SZ_WORD: begin
                w_misalign  = |mem_addr_i[1:0];
                w_be        = C_BE_W'(15) << w_off;
                w_sdata_rep = {(DATA_W/32){mem_sdata_i[31:0]}};
            end
            default: ;
        endcase
    end

    mem_lane_ext #(
        .DATA_W (DATA_W),
        .OFF_W  (C_OFF_W)
    ) u_lane_ext (
        .rdata  (bus.bus_rdata_i),
        .off    (r_off),
        .op     (r_op),
        .data   (w_load)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (rst == C_RST_ENABLE) begin
            r_state         <= C_ST_IDLE;
            r_waddr         <= '0;
            r_op            <= C_OP_NONE;
            r_off           <= '0;
            bus.bus_req_o   <= 1'b0;
            bus.bus_we_o    <= 1'b0;
            bus.bus_addr_o  <= '0;
            bus.bus_be_o    <= '0;
            bus.bus_wdata_o <= '0;
            waddr_o         <= '0;
            wdata_o         <= '0;
            we_o            <= 1'b0;
            misalign_o      <= 1'b0;
        end else begin
            we_o       <= 1'b0;
            misalign_o <= 1'b0;
            case (r_state)
                C_ST_IDLE: begin
                    if (valid_i) begin
                        if (w_size == SZ_NONE) begin
                            waddr_o <= waddr_i;
                            wdata_o <= wdata_i;
                            we_o    <= we_i;
                        end else if (w_misalign) begin
                            misalign_o <= 1'b1;
                        end else begin
                            r_state         <= C_ST_BUS;
                            r_waddr         <= waddr_i;
                            r_op            <= mem_op_i;
                            r_off           <= w_off;
                            bus.bus_req_o   <= 1'b1;
                            bus.bus_we_o    <= op_is_store(mem_op_i);
                            bus.bus_addr_o  <= {mem_addr_i[ADDR_W-1:C_OFF_W], {C_OFF_W{1'b0}}};
                            bus.bus_be_o    <= w_be;
                            bus.bus_wdata_o <= w_sdata_rep;
                        end
                    end
                end
                C_ST_BUS: begin
                    // Bus fields stay frozen until the ack; only the request drops.
                    if (bus.bus_ack_i) begin
                        r_state       <= C_ST_IDLE;
                        bus.bus_req_o <= 1'b0;
                        if (!bus.bus_we_o) begin
                            waddr_o <= r_waddr;
                            wdata_o <= w_load;
                            we_o    <= 1'b1;
                        end
                    end
                end
                default: r_state <= C_ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_lsu.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_lsu
// Description : Self-checking bench for mem_lsu (32-bit and 64-bit instances).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_lsu;
    import mem_lsu_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        valid, we, ready, we_o, mis_o;
    logic [4:0]  waddr, waddr_o;
    logic [3:0]  op;
    logic [31:0] wdata, addr, sdata, wdata_o;

    logic        valid64, we64, ready64, we_o64, mis_o64;
    logic [4:0]  waddr64, waddr_o64;
    logic [3:0]  op64;
    logic [31:0] addr64;
    logic [63:0] wdata64, sdata64, wdata_o64;

    mem_lsu_if #(.DATA_W(32), .ADDR_W(32)) bus32 ();
    mem_lsu_if #(.DATA_W(64), .ADDR_W(32)) bus64 ();

    mem_lsu #(.DATA_W(32), .ADDR_W(32), .REG_ADDR_W(5)) dut (
        .clk(clk), .rst(rst), .valid_i(valid), .ready_o(ready),
        .waddr_i(waddr), .wdata_i(wdata), .we_i(we), .mem_op_i(op),
        .mem_addr_i(addr), .mem_sdata_i(sdata), .bus(bus32.master),
        .waddr_o(waddr_o), .wdata_o(wdata_o), .we_o(we_o), .misalign_o(mis_o)
    );

    mem_lsu #(.DATA_W(64), .ADDR_W(32), .REG_ADDR_W(5)) dut64 (
        .clk(clk), .rst(rst), .valid_i(valid64), .ready_o(ready64),
        .waddr_i(waddr64), .wdata_i(wdata64), .we_i(we64), .mem_op_i(op64),
        .mem_addr_i(addr64), .mem_sdata_i(sdata64), .bus(bus64.master),
        .waddr_o(waddr_o64), .wdata_o(wdata_o64), .we_o(we_o64), .misalign_o(mis_o64)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        mis;
        logic [4:0]  waddr;
        logic [31:0] wdata;
    } wb_t;
    wb_t sb[$];

    always @(negedge clk) begin
        if (rst && (we_o || mis_o)) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected: got we_o=%0b misalign_o=%0b expected no output", we_o, mis_o);
            end else begin
                wb_t e;
                e = sb.pop_front();
                check("sb_misalign", 64'(mis_o), 64'(e.mis));
                check("sb_we", 64'(we_o), 64'(!e.mis));
                if (!e.mis) begin
                    check("sb_waddr", 64'(waddr_o), 64'(e.waddr));
                    check("sb_wdata", 64'(wdata_o), 64'(e.wdata));
                end
            end
        end
    end

    typedef struct {
        logic [3:0]  op;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [31:0] rdata;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        we;
        int          waits;
        logic [3:0]  be;
        logic [31:0] bwdata;
        logic        ewe;
        logic [31:0] ewdata;
        logic        emis;
    } vec_t;

    localparam int NV = 14;
    vec_t vecs[NV];

    task automatic run_vec(input vec_t v, input int idx);
        logic is_mem, is_store;
        int   low;
        is_mem   = (v.op != C_OP_NONE) && !v.emis;
        is_store = (v.op == C_OP_SB) || (v.op == C_OP_SH) || (v.op == C_OP_SW);
        @(negedge clk);
        check($sformatf("v%0d_ready_in", idx), 64'(ready), 64'd1);
        valid = 1'b1; op = v.op; addr = v.addr; sdata = v.sdata;
        waddr = v.waddr; wdata = v.wdata; we = v.we;
        bus32.bus_rdata_i = v.rdata;
        if (v.ewe || v.emis) sb.push_back('{v.emis, v.waddr, v.ewdata});
        @(negedge clk);
        valid = 1'b0; op = C_OP_NONE; we = 1'b0;
        if (!is_mem) begin
            check($sformatf("v%0d_no_req", idx), 64'(bus32.bus_req_o), 64'd0);
            check($sformatf("v%0d_ready", idx), 64'(ready), 64'd1);
            check($sformatf("v%0d_we_o", idx), 64'(we_o), 64'(v.ewe));
            check($sformatf("v%0d_misalign", idx), 64'(mis_o), 64'(v.emis));
        end else begin
            low = 0;
            for (int c = 0; c <= v.waits; c++) begin
                if (!ready) low++;
                check($sformatf("v%0d_c%0d_req", idx, c), 64'(bus32.bus_req_o), 64'd1);
                check($sformatf("v%0d_c%0d_bwe", idx, c), 64'(bus32.bus_we_o), 64'(is_store));
                check($sformatf("v%0d_c%0d_be", idx, c), 64'(bus32.bus_be_o), 64'(v.be));
                check($sformatf("v%0d_c%0d_baddr", idx, c), 64'(bus32.bus_addr_o), 64'(v.addr & ~32'h3));
                if (is_store)
                    check($sformatf("v%0d_c%0d_bwdata", idx, c), 64'(bus32.bus_wdata_o), 64'(v.bwdata));
                bus32.bus_ack_i = (c == v.waits);
                @(negedge clk);
            end
            bus32.bus_ack_i = 1'b0;
            check($sformatf("v%0d_ready_low", idx), 64'(low), 64'(v.waits + 1));
            check($sformatf("v%0d_req_drop", idx), 64'(bus32.bus_req_o), 64'd0);
            check($sformatf("v%0d_ready_back", idx), 64'(ready), 64'd1);
            check($sformatf("v%0d_we_after", idx), 64'(we_o), 64'(v.ewe));
        end
    endtask

    initial begin
        valid = 0; we = 0; op = C_OP_NONE; waddr = 0; wdata = 0; addr = 0; sdata = 0;
        valid64 = 0; we64 = 0; op64 = C_OP_NONE; waddr64 = 0; wdata64 = 0; addr64 = 0; sdata64 = 0;
        bus32.bus_ack_i = 0; bus32.bus_rdata_i = 0;
        bus64.bus_ack_i = 0; bus64.bus_rdata_i = 0;

        //          op        addr          sdata          rdata          wa  wdata         we  w  be       bwdata         ewe  ewdata         emis
        vecs[0]  = '{C_OP_NONE, 32'h0,      32'h0,         32'h0,         5'd3, 32'h1234,   1, 0, 4'b0000, 32'h0,         1, 32'h00001234, 0};
        vecs[1]  = '{C_OP_NONE, 32'h0,      32'h0,         32'h0,         5'd7, 32'h5,      0, 0, 4'b0000, 32'h0,         0, 32'h0,        0};
        vecs[2]  = '{C_OP_LB,   32'h103,    32'h0,         32'h80FFFFFF,  5'd9, 32'h0,      1, 3, 4'b1000, 32'h0,         1, 32'hFFFFFF80, 0};
        vecs[3]  = '{C_OP_LBU,  32'h103,    32'h0,         32'h80FFFFFF,  5'd10, 32'h0,     1, 3, 4'b1000, 32'h0,         1, 32'h00000080, 0};
        vecs[4]  = '{C_OP_SH,   32'h102,    32'h0000ABCD,  32'h0,         5'd0, 32'h0,      0, 1, 4'b1100, 32'hABCDABCD,  0, 32'h0,        0};
        vecs[5]  = '{C_OP_LW,   32'h101,    32'h0,         32'h0,         5'd1, 32'h0,      1, 0, 4'b0000, 32'h0,         0, 32'h0,        1};
        vecs[6]  = '{C_OP_LH,   32'h102,    32'h0,         32'h80011234,  5'd11, 32'h0,     1, 0, 4'b1100, 32'h0,         1, 32'hFFFF8001, 0};
        vecs[7]  = '{C_OP_LHU,  32'h100,    32'h0,         32'h1234F00D,  5'd12, 32'h0,     1, 2, 4'b0011, 32'h0,         1, 32'h0000F00D, 0};
        vecs[8]  = '{C_OP_LW,   32'h200,    32'h0,         32'hDEADBEEF,  5'd13, 32'h0,     1, 1, 4'b1111, 32'h0,         1, 32'hDEADBEEF, 0};
        vecs[9]  = '{C_OP_SB,   32'h201,    32'h123456A5,  32'h0,         5'd0, 32'h0,      0, 2, 4'b0010, 32'hA5A5A5A5,  0, 32'h0,        0};
        vecs[10] = '{C_OP_SW,   32'h204,    32'hCAFEF00D,  32'h0,         5'd0, 32'h0,      0, 0, 4'b1111, 32'hCAFEF00D,  0, 32'h0,        0};
        vecs[11] = '{C_OP_LH,   32'h101,    32'h0,         32'h0,         5'd2, 32'h0,      1, 0, 4'b0000, 32'h0,         0, 32'h0,        1};
        vecs[12] = '{C_OP_SW,   32'h206,    32'h11111111,  32'h0,         5'd0, 32'h0,      0, 0, 4'b0000, 32'h0,         0, 32'h0,        1};
        vecs[13] = '{C_OP_LB,   32'h102,    32'h0,         32'h007F0000,  5'd14, 32'h0,     1, 1, 4'b0100, 32'h0,         1, 32'h0000007F, 0};

        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_req", 64'(bus32.bus_req_o), 64'd0);
        check("rst_be", 64'(bus32.bus_be_o), 64'd0);
        check("rst_we_o", 64'(we_o), 64'd0);
        check("rst_wdata_o", 64'(wdata_o), 64'd0);
        check("rst_ready", 64'(ready), 64'd1);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < NV; i++) run_vec(vecs[i], i);

        // writeback followed by an idle cycle must drop we_o
        run_vec(vecs[0], 100);
        @(negedge clk);
        check("we_drop_idle", 64'(we_o), 64'd0);

        // stray ack while idle
        bus32.bus_rdata_i = 32'hFFFFFFFF;
        bus32.bus_ack_i = 1'b1;
        @(negedge clk);
        bus32.bus_ack_i = 1'b0;
        check("idle_ack_req", 64'(bus32.bus_req_o), 64'd0);
        check("idle_ack_we", 64'(we_o), 64'd0);
        check("idle_ack_ready", 64'(ready), 64'd1);

        // reset in the middle of a bus access, then a stray ack
        valid = 1'b1; op = C_OP_LW; addr = 32'h300; waddr = 5'd4;
        @(negedge clk);
        valid = 1'b0; op = C_OP_NONE;
        check("mid_req_set", 64'(bus32.bus_req_o), 64'd1);
        check("mid_ready_low", 64'(ready), 64'd0);
        #2 rst = 1'b0;
        #1;
        check("mid_rst_req", 64'(bus32.bus_req_o), 64'd0);
        check("mid_rst_be", 64'(bus32.bus_be_o), 64'd0);
        check("mid_rst_addr", 64'(bus32.bus_addr_o), 64'd0);
        check("mid_rst_waddr_o", 64'(waddr_o), 64'd0);
        check("mid_rst_wdata_o", 64'(wdata_o), 64'd0);
        check("mid_rst_ready", 64'(ready), 64'd1);
        @(negedge clk);
        rst = 1'b1;
        bus32.bus_ack_i = 1'b1;
        @(negedge clk);
        bus32.bus_ack_i = 1'b0;
        check("post_rst_ack_we", 64'(we_o), 64'd0);
        check("post_rst_ack_wdata", 64'(wdata_o), 64'd0);
        check("post_rst_ack_req", 64'(bus32.bus_req_o), 64'd0);

        // 64-bit bus: word in the upper half, sign extended to 64 bits
        @(negedge clk);
        valid64 = 1'b1; op64 = C_OP_LW; addr64 = 32'h104; waddr64 = 5'd6;
        bus64.bus_rdata_i = 64'h8000000100000000;
        @(negedge clk);
        valid64 = 1'b0; op64 = C_OP_NONE;
        check("w64_req", 64'(bus64.bus_req_o), 64'd1);
        check("w64_be", 64'(bus64.bus_be_o), 64'hF0);
        check("w64_addr", 64'(bus64.bus_addr_o), 64'h100);
        bus64.bus_ack_i = 1'b1;
        @(negedge clk);
        bus64.bus_ack_i = 1'b0;
        check("w64_we_o", 64'(we_o64), 64'd1);
        check("w64_waddr_o", 64'(waddr_o64), 64'd6);
        check("w64_wdata_o", wdata_o64, 64'hFFFFFFFF80000001);
        check("w64_req_drop", 64'(bus64.bus_req_o), 64'd0);

        @(negedge clk);
        check("sb_drained", 64'(sb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
